// File: rtl/adder_pkg.sv
// Shared constants and helpers for the pipelined add/subtract unit.
// Saturation bounds are produced wide and sliced to the operand width by the user.
package adder_pkg;

    localparam int   SEG_DEFAULT = 4;
    localparam logic OP_ADD      = 1'b0;
    localparam logic OP_SUB      = 1'b1;
    localparam int   SAT_MAX_W   = 128;

    function automatic logic [SAT_MAX_W-1:0] sat_max(input int w);
        return (SAT_MAX_W'(1) << (w - 1)) - SAT_MAX_W'(1);
    endfunction

    function automatic logic [SAT_MAX_W-1:0] sat_min(input int w);
        return SAT_MAX_W'(1) << (w - 1);
    endfunction

endpackage

// File: rtl/cla_segment.sv
// SEG-bit carry-lookahead adder segment; g/p summarise the whole segment
// so a higher level can look ahead across segments.
module cla_segment #(
    parameter int SEG = 4
) (
    input  logic [SEG-1:0] a,
    input  logic [SEG-1:0] b,
    input  logic           cin,
    output logic [SEG-1:0] s,
    output logic           cout,
    output logic           g,
    output logic           p
);
    logic [SEG-1:0] gi;
    logic [SEG-1:0] pi;
    logic [SEG:0]   c;

    assign gi = a & b;
    assign pi = a ^ b;

    // each carry is a flat sum of products of generates/propagates, not a ripple through c
    always_comb begin
        logic gen_acc;
        logic term;
        gen_acc = 1'b0;
        term    = 1'b0;
        c       = '0;
        g       = 1'b0;
        c[0]    = cin;
        for (int i = 0; i < SEG; i++) begin
            gen_acc = 1'b0;
            for (int j = 0; j <= i; j++) begin
                term = gi[j];
                for (int m = j + 1; m <= i; m++) term = term & pi[m];
                gen_acc = gen_acc | term;
            end
            term = cin;
            for (int m = 0; m <= i; m++) term = term & pi[m];
            c[i+1] = gen_acc | term;
            g      = gen_acc;
        end
    end

    assign s    = pi ^ c[SEG-1:0];
    assign cout = c[SEG];
    assign p    = &pi;

endmodule

// File: rtl/pipelined_adder.sv
// Pipelined add/subtract unit: stage k resolves operand chunk k, carry registered between stages.
// Define ADDER_SAT_EN to add the sat port and signed clamping of overflowed results.
module pipelined_adder
    import adder_pkg::*;
#(
    parameter int WIDTH  = 32,
    parameter int STAGES = 2,
    parameter int SEG    = SEG_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             op_sub,
`ifdef ADDER_SAT_EN
    input  logic             sat,
`endif
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);
    localparam int CHUNK = WIDTH / STAGES;
    localparam int NSEG  = CHUNK / SEG;

    logic adv;

    // x_*: token entering stage k; y_*: its sum/carry once chunk k is resolved
    logic             x_v [STAGES];
    logic [WIDTH-1:0] x_a [STAGES];
    logic [WIDTH-1:0] x_b [STAGES];
    logic [WIDTH-1:0] x_s [STAGES];
    logic             x_c [STAGES];
    logic [WIDTH-1:0] y_s [STAGES];
    logic             y_c [STAGES];
`ifdef ADDER_SAT_EN
    logic             x_sat [STAGES];
`endif

    assign adv      = !out_valid || out_ready;
    assign in_ready = adv;

    assign x_v[0] = in_valid;
    assign x_a[0] = a;
    assign x_b[0] = (op_sub == OP_SUB) ? ~b : b;
    assign x_c[0] = (op_sub == OP_SUB) ? 1'b1 : cin;
    assign x_s[0] = '0;
`ifdef ADDER_SAT_EN
    assign x_sat[0] = sat;
`endif

    genvar k, j;
    generate
        for (k = 0; k < STAGES; k++) begin : g_stage
            localparam logic [WIDTH-1:0] MASK = WIDTH'({CHUNK{1'b1}}) << (k * CHUNK);
            logic [NSEG:0]    sc;
            logic [CHUNK-1:0] cs;
            logic [NSEG-1:0]  sg;
            logic [NSEG-1:0]  sp;
            logic             unused_gp;

            assign sc[0] = x_c[k];
            for (j = 0; j < NSEG; j++) begin : g_seg
                cla_segment #(.SEG(SEG)) u_seg (
                    .a    (x_a[k][k*CHUNK + j*SEG +: SEG]),
                    .b    (x_b[k][k*CHUNK + j*SEG +: SEG]),
                    .cin  (sc[j]),
                    .s    (cs[j*SEG +: SEG]),
                    .cout (sc[j+1]),
                    .g    (sg[j]),
                    .p    (sp[j])
                );
            end
            assign unused_gp = ^{sg, sp};

            assign y_s[k] = (x_s[k] & ~MASK) | (WIDTH'(cs) << (k * CHUNK));
            assign y_c[k] = sc[NSEG];

            if (k < STAGES - 1) begin : g_reg
                // ---- stage k -> k+1 boundary ----
                logic             vld_p;
                logic [WIDTH-1:0] a_p;
                logic [WIDTH-1:0] b_p;
                logic [WIDTH-1:0] s_p;
                logic             c_p;

                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n)   vld_p <= 1'b0;
                    else if (adv) vld_p <= x_v[k];
                end

                always_ff @(posedge clk) begin
                    if (adv) begin
                        a_p <= x_a[k];
                        b_p <= x_b[k];
                        s_p <= y_s[k];
                        c_p <= y_c[k];
                    end
                end

                assign x_v[k+1] = vld_p;
                assign x_a[k+1] = a_p;
                assign x_b[k+1] = b_p;
                assign x_s[k+1] = s_p;
                assign x_c[k+1] = c_p;
`ifdef ADDER_SAT_EN
                logic sat_p;
                always_ff @(posedge clk) begin
                    if (adv) sat_p <= x_sat[k];
                end
                assign x_sat[k+1] = sat_p;
`endif
            end else begin : g_out
                // ---- final stage -> output boundary ----
                logic             ovf_n;
                logic [WIDTH-1:0] s_n;

                assign ovf_n = (x_a[k][WIDTH-1] == x_b[k][WIDTH-1]) &&
                               (y_s[k][WIDTH-1] != x_a[k][WIDTH-1]);
`ifdef ADDER_SAT_EN
                localparam logic [SAT_MAX_W-1:0] SMAX = sat_max(WIDTH);
                localparam logic [SAT_MAX_W-1:0] SMIN = sat_min(WIDTH);
                // overflow direction follows the shared operand sign
                assign s_n = (x_sat[k] && ovf_n)
                           ? (x_a[k][WIDTH-1] ? SMIN[WIDTH-1:0] : SMAX[WIDTH-1:0])
                           : y_s[k];
`else
                assign s_n = y_s[k];
`endif
                always_ff @(posedge clk or negedge rst_n) begin
                    if (!rst_n) begin
                        out_valid <= 1'b0;
                        s         <= '0;
                        cout      <= 1'b0;
                        ovf       <= 1'b0;
                    end else if (adv) begin
                        out_valid <= x_v[k];
                        if (x_v[k]) begin
                            s    <= s_n;
                            cout <= y_c[k];
                            ovf  <= ovf_n;
                        end
                    end
                end
            end
        end
    endgenerate

    assign zero = out_valid && (s == '0);

endmodule

// File: tb/tb_pipelined_adder.sv
// Directed bench for pipelined_adder (WIDTH=32, STAGES=2): latency, flags, throughput,
// backpressure and mid-flight reset; expectations follow ADDER_SAT_EN when it is defined.
module tb_pipelined_adder;
    localparam int W = 32;
`ifdef ADDER_SAT_EN
    localparam bit SAT_EN = 1'b1;
`else
    localparam bit SAT_EN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_n;
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cin;
    logic         op_sub;
    logic         sat;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    int           n_chk  = 0;
    int           n_pass = 0;
    int           n_rcv  = 0;
    int           base;
    logic [W+2:0] exp_q[$];   // {zero, ovf, cout, s}
    logic [W+2:0] exp_e;

    always #5 clk = ~clk;

    pipelined_adder #(.WIDTH(W), .STAGES(2), .SEG(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .op_sub    (op_sub),
`ifdef ADDER_SAT_EN
        .sat       (sat),
`endif
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want) n_pass++;
        else $display("FAIL %s: got %0h, want %0h", tag, got, want);
    endtask

    function automatic logic [W+2:0] model(input logic [W-1:0] ma, input logic [W-1:0] mb,
                                           input logic mc, input logic msub, input logic msat);
        logic [W:0]   full;
        logic [W-1:0] r;
        logic         co;
        logic         ov;
        if (msub) begin
            r  = ma - mb;
            co = (ma >= mb);
            ov = (ma[W-1] != mb[W-1]) && (r[W-1] != ma[W-1]);
        end else begin
            full = {1'b0, ma} + {1'b0, mb} + (W+1)'(mc);
            r    = full[W-1:0];
            co   = full[W];
            ov   = (ma[W-1] == mb[W-1]) && (r[W-1] != ma[W-1]);
        end
        if (SAT_EN && msat && ov) r = ma[W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
        return {(r == '0), ov, co, r};
    endfunction

    // scoreboard: record accepted operands, compare every delivered result in order
    always @(negedge clk) begin
        if (rst_n) begin
            if (in_valid && in_ready) exp_q.push_back(model(a, b, cin, op_sub, sat));
            if (out_valid && out_ready) begin
                n_rcv++;
                if (exp_q.size() == 0) begin
                    chk("spurious_out", out_valid, 1'b0);
                end else begin
                    exp_e = exp_q.pop_front();
                    chk("sb_s",    s,    exp_e[W-1:0]);
                    chk("sb_cout", cout, exp_e[W]);
                    chk("sb_ovf",  ovf,  exp_e[W+1]);
                    chk("sb_zero", zero, exp_e[W+2]);
                end
            end
        end
    end

    task automatic put(input logic [W-1:0] ta, input logic [W-1:0] tb,
                       input logic tc, input logic tsub, input logic tsat);
        a = ta; b = tb; cin = tc; op_sub = tsub; sat = tsat; in_valid = 1'b1;
    endtask

    // issue one op into an idle, draining pipe; returns at the negedge showing its result
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tc, input logic tsub, input logic tsat);
        int n;
        put(ta, tb, tc, tsub, tsat);
        @(posedge clk); #1;
        in_valid = 1'b0;
        n = 0;
        @(negedge clk);
        while (!out_valid && n < 10) begin
            @(negedge clk);
            n++;
        end
        chk("op_result_valid", out_valid, 1'b1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0;
        op_sub = 1'b0; sat = 1'b0; out_ready = 1'b1;
        repeat (2) @(negedge clk);
        chk("rst_out_valid", out_valid, 1'b0);
        chk("rst_s",         s,         32'h0);
        chk("rst_cout",      cout,      1'b0);
        chk("rst_ovf",       ovf,       1'b0);
        chk("rst_zero",      zero,      1'b0);
        chk("rst_in_ready",  in_ready,  1'b1);
        rst_n = 1'b1;
        @(posedge clk); #1;

        // carry through every bit, exact two-cycle latency
        put(32'hFFFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        chk("t1_lat1_valid", out_valid, 1'b0);
        @(negedge clk);
        chk("t1_lat2_valid", out_valid, 1'b1);
        chk("t1_s",    s,    32'h0);
        chk("t1_cout", cout, 1'b1);
        chk("t1_zero", zero, 1'b1);
        chk("t1_ovf",  ovf,  1'b0);
        @(posedge clk); #1;

        run_op(32'h5, 32'h7, 1'b1, 1'b1, 1'b0);   // cin ignored in subtract
        chk("t2a_s",    s,    32'hFFFF_FFFE);
        chk("t2a_cout", cout, 1'b0);
        chk("t2a_ovf",  ovf,  1'b0);
        @(posedge clk); #1;
        run_op(32'h8000_0000, 32'h1, 1'b0, 1'b1, 1'b0);
        chk("t2b_s",    s,    32'h7FFF_FFFF);
        chk("t2b_ovf",  ovf,  1'b1);
        chk("t2b_cout", cout, 1'b1);
        @(posedge clk); #1;

        run_op(32'h7FFF_FFFF, 32'h1, 1'b0, 1'b0, 1'b1);
        chk("t6a_s",    s,    SAT_EN ? 32'h7FFF_FFFF : 32'h8000_0000);
        chk("t6a_ovf",  ovf,  1'b1);
        chk("t6a_cout", cout, 1'b0);
        @(posedge clk); #1;
        run_op(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b0, 1'b1);
        chk("t6b_s",    s,    SAT_EN ? 32'h8000_0000 : 32'h0);
        chk("t6b_zero", zero, SAT_EN ? 1'b0 : 1'b1);
        chk("t6b_cout", cout, 1'b1);
        @(posedge clk); #1;

        // back-to-back stream, one result per cycle
        base = n_rcv;
        for (int i = 0; i < 100; i++) begin
            put((i % 10 == 0) ? 32'hFFFF_FFFF : $urandom, $urandom,
                1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 1'b0);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        chk("t3_rate", n_rcv - base, 98);
        repeat (4) @(posedge clk); #1;
        chk("t3_count",   n_rcv - base, 100);
        chk("t3_drained", exp_q.size(), 0);

        // backpressure with a full pipe, then simultaneous accept and drain
        out_ready = 1'b0;
        base = n_rcv;
        put(32'h1234_5678, 32'h1111_1111, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        put(32'h10, 32'h20, 1'b0, 1'b1, 1'b0);
        @(posedge clk); #1;
        put(32'h0, 32'h0, 1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t4_in_ready",  in_ready,  1'b0);
            chk("t4_out_valid", out_valid, 1'b1);
            chk("t4_s_hold",    s,         32'h2345_6789);
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk); #1;
        chk("t4_count",   n_rcv - base, 3);
        chk("t4_drained", exp_q.size(), 0);

        // reset with two tokens in flight
        put(32'hAAAA_0000, 32'h0000_5555, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        put(32'h1, 32'h2, 1'b0, 1'b0, 1'b0);
        @(posedge clk); #1;
        in_valid = 1'b0;
        chk("t5_pre_valid", out_valid, 1'b1);
        rst_n = 1'b0;
        exp_q.delete();
        #1;
        chk("t5_flush_valid", out_valid, 1'b0);
        chk("t5_flush_s",     s,         32'h0);
        @(negedge clk); #2;
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk("t5_no_stale", out_valid, 1'b0);
        end
        @(posedge clk); #1;
        run_op(32'h3, 32'h4, 1'b1, 1'b0, 1'b0);
        chk("t5_recover_s", s, 32'h8);
        @(posedge clk); #1;
        repeat (3) @(posedge clk); #1;
        chk("end_drained", exp_q.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
